// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: game-tick prescaler, IDLE/READY/PLAY/OVER flow, score keeping.
// Optional MOLE_HIGH_SCORE_EN keeps the best final score across games until reset.
module mole_round_ctrl #(
  parameter int TICK_DIV    = 100000000,
  parameter int READY_TICKS = 3,
  parameter int TIME_BITS   = 6,
  parameter int SCORE_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hit,
  input  logic [TIME_BITS-1:0]  time_left,
  output logic                  time_en,
  output logic                  time_srst,
  output logic                  tick,
  output logic [1:0]            state,
  output logic [SCORE_BITS-1:0] score,
  output logic                  game_over,
  output logic [SCORE_BITS-1:0] high_score
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int RW = $clog2(READY_TICKS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, READY = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

  state_t                st;
  logic [PW-1:0]         presc;
  logic [RW-1:0]         ready_cnt;
  logic                  start_q;
  logic                  start_rise;
  logic [SCORE_BITS-1:0] score_inc;

  assign start_rise = start & ~start_q;
  assign tick       = (presc == PW'(TICK_DIV - 1));
  // Saturating increment; also the final score seen by the high-score capture.
  assign score_inc  = (hit && (score != '1)) ? score + 1'b1 : score;

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= IDLE;
      score     <= '0;
      presc     <= '0;
      ready_cnt <= '0;
      start_q   <= 1'b1;
    end else begin
      start_q <= start;
      presc   <= ((st == READY) || (st == PLAY)) ? (tick ? '0 : presc + 1'b1) : '0;
      case (st)
        IDLE, OVER: begin
          if (start_rise) begin
            st        <= READY;
            score     <= '0;
            ready_cnt <= RW'(READY_TICKS);
          end
        end
        READY: begin
          if (tick) begin
            ready_cnt <= ready_cnt - 1'b1;
            if (ready_cnt == RW'(1)) st <= PLAY;
          end
        end
        PLAY: begin
          score <= score_inc;
          if (time_left == '0) begin
            st    <= OVER;
            presc <= '0;
          end
        end
      endcase
    end
  end

  assign state     = st;
  assign game_over = (st == OVER);
  assign time_en   = (st == PLAY) & tick;
  assign time_srst = (st == IDLE) | (st == READY);

`ifdef MOLE_HIGH_SCORE_EN
  logic [SCORE_BITS-1:0] hs;
  always_ff @(posedge clk) begin
    if (reset) hs <= '0;
    else if ((st == PLAY) && (time_left == '0) && (score_inc > hs)) hs <= score_inc;
  end
  assign high_score = hs;
`else
  assign high_score = '0;
`endif

endmodule
